// File: rtl/alu_mult_seq.sv
// Shift-and-add sequencer for an unsigned W x W -> 2W multiply. It processes one
// multiplier bit per clock and uses an external combinational ALU for the adds.
module alu_mult_seq #(
  parameter int         W        = 32,
  parameter logic [1:0] SEL_ADD  = 2'b10,
  parameter logic       ADD_BINV = 1'b1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           abort,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product,
  output logic [W-1:0]   alu_in1,
  output logic [W-1:0]   alu_in2,
  output logic           alu_binvert,
  output logic           alu_carryin,
  output logic [1:0]     alu_sel,
  input  logic [W-1:0]   alu_result,
  input  logic           alu_carryout
);

  localparam int CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [W-1:0]     mcand;
  logic [W-1:0]     acc_hi;
  logic [W-1:0]     acc_lo;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // acc_lo starts as the multiplier and is shifted out one bit per step, while product bits shift in from acc_hi.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= a;
            acc_hi <= '0;
            acc_lo <= b;
            cnt    <= '0;
            busy   <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            busy <= 1'b0;
          end else begin
            if (acc_lo[0]) begin
              {acc_hi, acc_lo} <= {alu_carryout, alu_result, acc_lo[W-1:1]};
            end else begin
              {acc_hi, acc_lo} <= {1'b0, acc_hi, acc_lo[W-1:1]};
            end
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          product <= {acc_hi, acc_lo};
          done    <= 1'b1;
          busy    <= 1'b0;
        end
        default: busy <= 1'b0;
      endcase
    end
  end

  assign alu_in1     = acc_hi;
  assign alu_in2     = mcand;
  assign alu_binvert = ADD_BINV;
  assign alu_carryin = 1'b0;
  assign alu_sel     = SEL_ADD;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Bench for alu_mult_seq. It models the external ALU, runs a table of fixed vectors,
// runs the multi-cycle corner sequences, and runs random operands checked against a*b.
module tb_alu_mult_seq;
  localparam int         W        = 32;
  localparam logic [1:0] SEL_ADD  = 2'b10;
  localparam logic       ADD_BINV = 1'b1;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic           abort;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [W-1:0]   alu_in1;
  logic [W-1:0]   alu_in2;
  logic           alu_binvert;
  logic           alu_carryin;
  logic [1:0]     alu_sel;
  logic [W-1:0]   alu_result;
  logic           alu_carryout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mult_seq #(.W(W), .SEL_ADD(SEL_ADD), .ADD_BINV(ADD_BINV)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .a(a), .b(b),
    .busy(busy), .done(done), .product(product), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_binvert(alu_binvert), .alu_carryin(alu_carryin), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carryout(alu_carryout)
  );

  // External ALU: and/or/add, where Binvert == ADD_BINV passes in2 through unchanged.
  logic [W:0]   alu_sum;
  logic [W-1:0] alu_in2_eff;
  always_comb begin
    alu_in2_eff  = (alu_binvert == ADD_BINV) ? alu_in2 : ~alu_in2;
    alu_sum      = {1'b0, alu_in1} + {1'b0, alu_in2_eff} + {{W{1'b0}}, alu_carryin};
    alu_carryout = alu_sum[W];
    case (alu_sel)
      2'b00:   alu_result = alu_in1 & alu_in2_eff;
      2'b01:   alu_result = alu_in1 | alu_in2_eff;
      default: alu_result = alu_sum[W-1:0];
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      chk("alu_sel_const", 64'(alu_sel), 64'(SEL_ADD));
      chk("alu_binvert_const", 64'(alu_binvert), 64'(ADD_BINV));
      chk("alu_carryin_const", 64'(alu_carryin), 64'd0);
    end
  end

  // Count the edges until done, with a bound. busy samples are counted along the way.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic [63:0] exp);
    int lat, bcnt;
    a = ta; b = tb2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'd1);
    chk("alu_in1_start", 64'(alu_in1), 64'd0);
    chk("alu_in2_mcand", 64'(alu_in2), 64'(ta));
    wait_done(lat, bcnt);
    chk("done_latency", 64'(lat), 64'd33);
    chk("busy_cycles", 64'(bcnt), 64'd33);
    chk("product", product, exp);
    chk("busy_at_done", 64'(busy), 64'd0);
    $display("txn a=%h b=%h product=%h expected=%h latency=%0d", ta, tb2, product, exp, lat);
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("product_hold", product, exp);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [63:0]  p;
  } vec_t;
  vec_t vecs[10];

  initial begin
    int lat, bcnt, k, dseen;
    logic [W-1:0] ra, rb;
    logic [63:0]  rexp;

    vecs[0] = '{32'd3, 32'd5, 64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'h0, 32'h1234_5678, 64'h0};
    vecs[3] = '{32'h1, 32'h8000_0000, 64'h0000_0000_8000_0000};
    vecs[4] = '{32'hFFFF_FFFF, 32'h1, 64'h0000_0000_FFFF_FFFF};
    vecs[5] = '{32'h1, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[7] = '{32'hFFFF_FFFF, 32'h2, 64'h0000_0001_FFFF_FFFE};
    vecs[8] = '{32'd1000, 32'd1000, 64'd1000000};
    vecs[9] = '{32'h1234_5678, 32'h0, 64'h0};

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0;
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_product", product, 64'd0);
    chk("rst_alu_in1", 64'(alu_in1), 64'd0);
    chk("rst_alu_in2", 64'(alu_in2), 64'd0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].p);

    // Abort mid-op with an ignored start just before it.
    run_op(32'd3, 32'd5, 64'hF);
    a = 32'd7; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    a = 32'd2; b = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_product_kept", product, 64'hF);
    dseen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dseen++;
    end
    chk("abort_no_done", 64'(dseen), 64'd0);
    chk("abort_idle_busy", 64'(busy), 64'd0);
    run_op(32'd7, 32'd9, 64'd63);

    // A start pulse in the middle of an op must not recapture the operands.
    a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    a = 32'd2; b = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("ignored_start_product", product, 64'd30);
    $display("txn a=5 b=6 with mid-op start, product=%h", product);
    @(posedge clk); #1;

    // An abort while the op is in its final step is ignored.
    a = 32'd4; b = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_in_done_done", 64'(done), 64'd1);
    chk("abort_in_done_product", product, 64'd16);
    $display("txn a=4 b=4 abort in final step, product=%h", product);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of an op.
    a = 32'd3; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_product", product, 64'd0);
    chk("midrst_alu_in1", 64'(alu_in1), 64'd0);
    chk("midrst_alu_in2", 64'(alu_in2), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'd10, 32'd10, 64'd100);

    // Back-to-back ops with start held high.
    a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    a = 32'd8; b = 32'd9;
    wait_done(lat, bcnt);
    chk("b2b_first_latency", 64'(lat), 64'd33);
    chk("b2b_first_product", product, 64'd42);
    $display("txn a=6 b=7 back-to-back product=%h", product);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
      if (k == 1) start = 1'b0;
    end while (!done && k < 100);
    chk("b2b_done_spacing", 64'(k), 64'd34);
    chk("b2b_second_product", product, 64'd72);
    $display("txn a=8 b=9 back-to-back product=%h spacing=%0d", product, k);
    @(posedge clk); #1;

    // Random operands checked against plain multiplication.
    for (int i = 0; i < 16; i++) begin
      ra = (i % 5 == 0) ? 32'hFFFF_FFFF : W'($urandom);
      rb = W'($urandom);
      rexp = {32'b0, ra} * {32'b0, rb};
      run_op(ra, rb, rexp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
